// File: rtl/rca4_pkg.sv
// rca4_pkg: shared width, latency and word types for the 4-bit ripple-carry
// adder slice of the carry-select datapath.
package rca4_pkg;

  localparam int RCA4_W       = 4;
  localparam int RCA4_LATENCY = 1;

  typedef logic [RCA4_W-1:0] rca4_word_t;
  typedef logic [RCA4_W:0]   rca4_res_t;

endpackage : rca4_pkg

// File: rtl/rca4_full_adder.sv
// full_adder: single-bit combinational full-adder cell, one link of the
// ripple carry chain inside rca4.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic prop_s;

  assign prop_s = a ^ b;
  assign sum    = prop_s ^ cin;
  assign cout   = (a & b) | (cin & prop_s);

endmodule : full_adder

// File: rtl/rca4.sv
// rca4: 4-bit ripple-carry adder with registered {cout, sum}.
// Optional feature: define RCA4_OVF_EN to add the registered signed-overflow
// output ovf (carry into the MSB xor carry out of the MSB).
module rca4
  import rca4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RCA4_W-1:0] a,
  input  logic [RCA4_W-1:0] b,
  input  logic              cin,
  output logic [RCA4_W-1:0] sum,
  output logic              cout
`ifdef RCA4_OVF_EN
  ,
  output logic              ovf
`endif
);

  // carry_s[i] is the carry into bit i; carry_s[RCA4_W] is the carry-out.
  logic [RCA4_W:0]   carry_s;
  rca4_word_t        sum_s;
  rca4_word_t        sum_r;
  logic              cout_r;

  assign carry_s[0] = cin;

  // True ripple chain: each cell waits on the previous cell's carry.
  for (genvar i = 0; i < RCA4_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_s[i]),
      .sum  (sum_s[i]),
      .cout (carry_s[i+1])
    );
  end

  // Output register: reset wins, otherwise load the new result every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r  <= {RCA4_W{1'b0}};
      cout_r <= 1'b0;
    end else begin
      sum_r  <= sum_s;
      cout_r <= carry_s[RCA4_W];
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

`ifdef RCA4_OVF_EN
  logic ovf_s;
  logic ovf_r;

  // Two's-complement overflow: carries into and out of the sign bit differ.
  assign ovf_s = carry_s[RCA4_W] ^ carry_s[RCA4_W-1];

  // Overflow register, aligned with sum/cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_s;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule : rca4

// File: tb/tb_rca4.sv
// tb_rca4: directed + random self-checking bench for rca4 against an
// arithmetic reference model (a + b + cin, signed range check for ovf).
module tb_rca4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
`ifdef RCA4_OVF_EN
  logic       ovf;
`endif

  int total;
  int bad;

  // Expected outputs currently held by the register (previous step).
  logic [3:0] prev_sum;
  logic       prev_cout;
  logic       prev_ovf;
  bit         prev_valid;

  rca4 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
`ifdef RCA4_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // One cycle: apply inputs at negedge, confirm outputs still hold the
  // previous result (no combinational path), then check after the edge.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb,
                      input logic tc, input logic tr, input string tag);
    int res;
    int sres;
    int sa;
    int sb;
    logic [3:0] esum;
    logic ecout;
    logic eovf;
    @(negedge clk);
    a = ta; b = tb; cin = tc; rst = tr;
    #1;
    if (prev_valid) begin
      check({tag, "/hold_sum"}, int'(sum), int'(prev_sum));
      check({tag, "/hold_cout"}, int'(cout), int'(prev_cout));
    end
    res  = int'(ta) + int'(tb) + int'(tc);
    sa   = (int'(ta) >= 8) ? int'(ta) - 16 : int'(ta);
    sb   = (int'(tb) >= 8) ? int'(tb) - 16 : int'(tb);
    sres = sa + sb + int'(tc);
    if (tr) begin
      esum = 4'd0; ecout = 1'b0; eovf = 1'b0;
    end else begin
      esum  = 4'(res % 16);
      ecout = (res >= 16);
      eovf  = (sres > 7) || (sres < -8);
    end
    @(posedge clk);
    #1;
    check({tag, "/sum"}, int'(sum), int'(esum));
    check({tag, "/cout"}, int'(cout), int'(ecout));
`ifdef RCA4_OVF_EN
    check({tag, "/ovf"}, int'(ovf), int'(eovf));
`endif
    prev_sum   = esum;
    prev_cout  = ecout;
    prev_ovf   = eovf;
    prev_valid = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    prev_valid = 1'b0;
    rst = 1'b1;
    a = 4'd0; b = 4'd0; cin = 1'b0;

    // Reset held two edges with all-ones operands, then release.
    step(4'd15, 4'd15, 1'b1, 1'b1, "reset0");
    step(4'd15, 4'd15, 1'b1, 1'b1, "reset1");
    step(4'd15, 4'd15, 1'b1, 1'b0, "release");

    // Exhaustive sweep, inputs changing every cycle.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 2; k++) begin
          step(4'(i), 4'(j), 1'(k), 1'b0, "sweep");
        end
      end
    end

    // Carry-ripple edges.
    step(4'd15, 4'd0, 1'b1, 1'b0, "ripple_f_0_1");
    step(4'd7,  4'd9, 1'b0, 1'b0, "ripple_7_9_0");
    step(4'd0,  4'd0, 1'b1, 1'b0, "ripple_0_0_1");

    // Back-to-back alternation.
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) step(4'd3, 4'd4, 1'b0, 1'b0, "pipe_a");
      else            step(4'd8, 4'd8, 1'b1, 1'b0, "pipe_b");
    end

    // Mid-stream reset discards the in-flight result.
    step(4'd9, 4'd2, 1'b1, 1'b0, "pre_mid");
    step(4'd5, 4'd6, 1'b0, 1'b1, "mid_rst");
    step(4'd5, 4'd6, 1'b0, 1'b0, "mid_rel");

    // Overflow corner cases (ovf checked only when the port exists).
    step(4'd7,  4'd1, 1'b0, 1'b0, "ovf_7_1");
    step(4'd8,  4'd8, 1'b0, 1'b0, "ovf_8_8");
    step(4'd15, 4'd1, 1'b0, 1'b0, "ovf_f_1");

    // Random operands with occasional reset.
    for (int r = 0; r < 200; r++) begin
      step(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
           1'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0),
           "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rca4
